// File: rtl/l1d_pkg.sv
// Shared L1D tag-controller definitions: default address-field widths, FSM states,
// and the line-alignment helper used to form refill addresses.
package l1d_pkg;

  localparam int L1D_ADDR_W     = 32;
  localparam int L1D_TAG_W      = 20;
  localparam int L1D_NUM_SETS   = 64;
  localparam int L1D_NUM_WAYS   = 4;
  localparam int L1D_IDX_W      = $clog2(L1D_NUM_SETS);
  localparam int L1D_WAY_W      = $clog2(L1D_NUM_WAYS);
  localparam int L1D_OFF_W      = L1D_ADDR_W - L1D_TAG_W - L1D_IDX_W;
  localparam int L1D_MAX_ADDR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    UPDATE,
    RESP
  } l1d_state_t;

  // Clears the byte-offset bits; callers size the result back to their address width.
  function automatic logic [L1D_MAX_ADDR_W-1:0] line_align(
    input logic [L1D_MAX_ADDR_W-1:0] addr,
    input int                        off_w
  );
    logic [L1D_MAX_ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/l1_plru_tree.sv
// Per-set tree pseudo-LRU state: touch updates the path to point away from a way,
// victim follows the bits from the root (0 = lower half); single-cycle update, no stalls.
module l1_plru_tree
  import l1d_pkg::*;
#(
  parameter int NUM_SETS = L1D_NUM_SETS,
  parameter int NUM_WAYS = L1D_NUM_WAYS,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WAY_W-1:0] victim
);

  logic [NUM_WAYS-2:0] tree_q [NUM_SETS];
  logic [NUM_WAYS-2:0] touch_mask;
  logic [NUM_WAYS-2:0] touch_val;

  // Heap numbering: root is node 1, children of n are 2n and 2n+1, bit n lives at n-1.
  always_comb begin
    int               node;
    logic [WAY_W-1:0] sh;
    logic [NUM_WAYS-2:0] bit_l;
    touch_mask = '0;
    touch_val  = '0;
    node       = 0;
    sh         = '0;
    bit_l      = '0;
    for (int l = 0; l < WAY_W; l++) begin
      node       = (NUM_WAYS + int'(touch_way)) >> (WAY_W - l);
      bit_l      = (NUM_WAYS-1)'(1) << (node - 1);
      sh         = touch_way >> (WAY_W - 1 - l);
      touch_mask = touch_mask | bit_l;
      touch_val  = touch_val | ({(NUM_WAYS-1){~sh[0]}} & bit_l);
    end
  end

  always_comb begin
    int                  node;
    logic [NUM_WAYS-2:0] sh;
    node = 1;
    sh   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = tree_q[rd_idx] >> (node - 1);
      node = 2 * node + int'(sh[0]);
    end
    victim = WAY_W'(node - NUM_WAYS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else if (touch_en) begin
      tree_q[touch_idx] <= (tree_q[touch_idx] & ~touch_mask) | (touch_val & touch_mask);
    end
  end

endmodule

// File: rtl/l1_tag_ctrl.sv
// L1D tag controller: hit resp 2 cycles after accept, miss resp 2 cycles after refill_ack; req_ready only in IDLE, no resp backpressure.
// Replacement: global round-robin pointer by default, tree pseudo-LRU when L1D_PLRU_EN is defined.
module l1_tag_ctrl
  import l1d_pkg::*;
#(
  parameter int ADDR_W   = L1D_ADDR_W,
  parameter int TAG_W    = L1D_TAG_W,
  parameter int NUM_SETS = L1D_NUM_SETS,
  parameter int NUM_WAYS = L1D_NUM_WAYS,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS),
  localparam int OFF_W   = ADDR_W - TAG_W - IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WAY_W-1:0]          resp_way,
  output logic                      refill_req_valid,
  output logic [ADDR_W-1:0]         refill_req_addr,
  input  logic                      refill_ack,
  output logic                      ta_we,
  output logic [IDX_W-1:0]          ta_index,
  output logic [WAY_W-1:0]          ta_way,
  output logic [TAG_W-1:0]          ta_tag,
  input  logic [TAG_W*NUM_WAYS-1:0] ta_tag_in,
  input  logic [NUM_WAYS-1:0]       ta_valid_in
);

  l1d_state_t        state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [TAG_W-1:0]  lat_tag;
  logic [WAY_W-1:0]  fill_way_q;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              any_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  policy_way;
  logic [WAY_W-1:0]  victim_way;

  assign lat_tag   = lat_addr_q[ADDR_W-1 -: TAG_W];
  assign ta_index  = lat_addr_q[OFF_W +: IDX_W];
  assign req_ready = (state_q == IDLE);

  // Scan from the top so the lowest matching / invalid way is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (ta_valid_in[w] && (ta_tag_in[w*TAG_W +: TAG_W] == lat_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!ta_valid_in[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = any_inv ? inv_way : policy_way;

`ifdef L1D_PLRU_EN
  logic             plru_touch_en;
  logic [WAY_W-1:0] plru_touch_way;

  assign plru_touch_en  = ((state_q == LOOKUP) && hit) || (state_q == UPDATE);
  assign plru_touch_way = (state_q == UPDATE) ? fill_way_q : hit_way;

  l1_plru_tree #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (plru_touch_en),
    .touch_idx (ta_index),
    .touch_way (plru_touch_way),
    .rd_idx    (ta_index),
    .victim    (policy_way)
  );
`else
  logic [WAY_W-1:0] rr_ptr_q;
  logic             used_policy_q;

  assign policy_way = rr_ptr_q;

  // The pointer only advances when every way was valid, so cold fills do not skew it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      used_policy_q <= 1'b0;
    end else begin
      if (state_q == LOOKUP) begin
        used_policy_q <= !hit && !any_inv;
      end
      if ((state_q == UPDATE) && used_policy_q) begin
        rr_ptr_q <= rr_ptr_q + WAY_W'(1);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? RESP : REFILL;
      REFILL:  if (refill_ack) state_d = UPDATE;
      UPDATE:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      lat_addr_q       <= '0;
      fill_way_q       <= '0;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      refill_req_valid <= 1'b0;
      refill_req_addr  <= '0;
      ta_we            <= 1'b0;
      ta_way           <= '0;
      ta_tag           <= '0;
    end else begin
      state_q          <= state_d;
      resp_valid       <= (state_d == RESP);
      refill_req_valid <= (state_d == REFILL);
      ta_we            <= (state_d == UPDATE);

      if ((state_q == IDLE) && req_valid) begin
        lat_addr_q <= req_addr;
      end

      if ((state_q == LOOKUP) && hit) begin
        resp_hit <= 1'b1;
        resp_way <= hit_way;
      end

      if ((state_q == LOOKUP) && !hit) begin
        fill_way_q      <= victim_way;
        refill_req_addr <= ADDR_W'(line_align(L1D_MAX_ADDR_W'(lat_addr_q), OFF_W));
      end

      if ((state_q == REFILL) && refill_ack) begin
        ta_way <= fill_way_q;
        ta_tag <= lat_tag;
      end

      if (state_q == UPDATE) begin
        resp_hit <= 1'b0;
        resp_way <= fill_way_q;
      end
    end
  end

endmodule
